ctrl_pkt_arbiter: RTL

//  Packet-atomic round-robin arbiter merging NUM_SRC control-packet AXIS sources onto the single
//  RMT control chain (parser -> stage -> deparser ctrl_* ports).
//  The chain has no tready, so this block alone sequences packets, paces them with an idle gap,
//  and truncates oversize packets so no stage sees an unterminated config write.

---
 rtl/ctrl_pkt_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ctrl_pkt_arbiter.sv
// ctrl_pkt_arbiter: packet-atomic round-robin merge of NUM_SRC AXIS control sources onto the
// backpressure-free RMT control chain, with a post-packet idle gap and oversize truncation.
module ctrl_pkt_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_SRC              = 2,
    parameter int GAP_CYCLES           = 4,
    parameter int MAX_BEATS            = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_SRC*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_SRC*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_SRC*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_SRC-1:0]                        s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                        s_axis_tlast,
    output logic [NUM_SRC-1:0]                        s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]            ctrl_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]          ctrl_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]           ctrl_m_axis_tuser,
    output logic                                      ctrl_m_axis_tvalid,
    output logic                                      ctrl_m_axis_tlast,
    output logic                                      oversize_err
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int SW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;
    localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t          state_q, state_d;
    logic [SW-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick, next_src;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic [KW-1:0]   tkeep_q, tkeep_d;
    logic [UW-1:0]   tuser_q, tuser_d;
    logic            tvalid_q, tvalid_d, tlast_q, tlast_d, err_q, err_d;
    logic            acc, last, full;
    int              idx;

    // Scan downward so the nearest valid source at or after rr_ptr wins.
    always_comb begin
        pick = rr_ptr_q;
        idx  = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (s_axis_tvalid[idx]) pick = SW'(idx);
        end
    end

    assign next_src      = (grant_q == SW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
    assign s_axis_tready = (state_q == XFER || state_q == DRAIN) ? NUM_SRC'(1) << grant_q : '0;
    assign acc           = s_axis_tvalid[grant_q] & s_axis_tready[grant_q];
    assign last          = s_axis_tlast[grant_q];
    assign full          = (beat_cnt_q + 1'b1) == BW'(MAX_BEATS);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tuser_d    = tuser_q;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (|s_axis_tvalid) begin
                grant_d    = pick;
                beat_cnt_d = '0;
                state_d    = XFER;
            end
            XFER: if (acc) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                tdata_d    = s_axis_tdata[int'(grant_q)*DW +: DW];
                tkeep_d    = s_axis_tkeep[int'(grant_q)*KW +: KW];
                tuser_d    = s_axis_tuser[int'(grant_q)*UW +: UW];
                tvalid_d   = 1'b1;
                tlast_d    = last | full;
                err_d      = ~last & full;
                if (last) begin
                    rr_ptr_d  = next_src;
                    gap_cnt_d = '0;
                    state_d   = POST;
                end else if (full) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: if (acc && last) begin
                rr_ptr_d  = next_src;
                gap_cnt_d = '0;
                state_d   = POST;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tuser_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            err_q      <= err_d;
        end
    end

    assign ctrl_m_axis_tdata  = tdata_q;
    assign ctrl_m_axis_tkeep  = tkeep_q;
    assign ctrl_m_axis_tuser  = tuser_q;
    assign ctrl_m_axis_tvalid = tvalid_q;
    assign ctrl_m_axis_tlast  = tlast_q;
    assign oversize_err       = err_q;
endmodule
